sort4_ctrl: RTL and testbench

//  Sorting engine built around one shared 4-bit magnitude comparator. It holds N nibble entries,

---
 rtl/sort4_pkg.sv | 15 +
 rtl/sort4_cmp.sv | 14 +
 rtl/sort4_ctrl.sv | 142 ++++++++++++++
 tb/tb_sort4_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sort4_pkg.sv
// Shared types and helpers for the nibble bubble-sort sequencer.
package sort4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ascending order exchanges when left is larger; descending when left is smaller.
  function automatic logic swap_select(input logic oa, input logic ob, input logic descend);
    return descend ? ob : oa;
  endfunction

endpackage

// File: rtl/sort4_cmp.sv
// Unsigned 4-bit magnitude comparator: exactly one of oa/oe/ob is high.
module sort4_cmp (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       oa,
  output logic       oe,
  output logic       ob
);

  assign oa = (a > b);
  assign oe = (a == b);
  assign ob = (a < b);

endmodule

// File: rtl/sort4_ctrl.sv
// In-place bubble sorter over N nibble entries, one compare-and-swap per clock
// through a single shared comparator, with early exit on a swap-free pass.
module sort4_ctrl
  import sort4_pkg::*;
#(
  parameter int N       = 4,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 4,
  parameter bit DESCEND = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [3:0]       load_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] swap_cnt,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [3:0]       rd_data
);

  localparam logic [IDX_W-1:0] PASS_MAX = IDX_W'(N - 2);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] j_reg, j_next;
  logic [IDX_W-1:0] pass_reg, pass_next;
  logic             swapped_reg, swapped_next;
  logic [CNT_W-1:0] swap_cnt_reg, swap_cnt_next;
  logic [3:0]       entry_reg [N];

  logic [IDX_W-1:0] j_plus1;
  logic [IDX_W-1:0] last_j;
  logic [3:0]       cmp_a, cmp_b;
  logic             cmp_oa, cmp_oe, cmp_ob;
  logic             load_en, swap_en, pass_swapped;

  assign j_plus1 = j_reg + IDX_W'(1);
  assign last_j  = PASS_MAX - pass_reg;
  assign cmp_a   = entry_reg[j_reg];
  assign cmp_b   = entry_reg[j_plus1];
  assign rd_data = entry_reg[rd_idx];
  assign swap_cnt = swap_cnt_reg;

  sort4_cmp u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .oa (cmp_oa),
    .oe (cmp_oe),
    .ob (cmp_ob)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      j_reg        <= '0;
      pass_reg     <= '0;
      swapped_reg  <= 1'b0;
      swap_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      j_reg        <= j_next;
      pass_reg     <= pass_next;
      swapped_reg  <= swapped_next;
      swap_cnt_reg <= swap_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    j_next        = j_reg;
    pass_next     = pass_reg;
    swapped_next  = swapped_reg;
    swap_cnt_next = swap_cnt_reg;
    load_en       = 1'b0;
    swap_en       = 1'b0;
    pass_swapped  = swapped_reg;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (load) begin
          load_en = 1'b1;
        end else if (start) begin
          state_next    = ST_SORT;
          j_next        = '0;
          pass_next     = '0;
          swapped_next  = 1'b0;
          swap_cnt_next = '0;
        end
      end
      ST_SORT: begin
        busy    = 1'b1;
        // Equal pairs never exchange, which keeps the sort stable.
        swap_en = !cmp_oe && swap_select(cmp_oa, cmp_ob, DESCEND);
        if (swap_en) begin
          swap_cnt_next = swap_cnt_reg + CNT_W'(1);
        end
        pass_swapped = swapped_reg | swap_en;
        if (j_reg == last_j) begin
          if (!pass_swapped || pass_reg == PASS_MAX) begin
            state_next   = ST_DONE;
            swapped_next = pass_swapped;
          end else begin
            pass_next    = pass_reg + IDX_W'(1);
            j_next       = '0;
            swapped_next = 1'b0;
          end
        end else begin
          j_next       = j_plus1;
          swapped_next = pass_swapped;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Each entry is written either by the load port or as one half of the active swap pair.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg[gi] <= 4'h0;
        end else if (load_en && load_idx == IDX_W'(gi)) begin
          entry_reg[gi] <= load_data;
        end else if (swap_en && j_reg == IDX_W'(gi)) begin
          entry_reg[gi] <= cmp_b;
        end else if (swap_en && j_plus1 == IDX_W'(gi)) begin
          entry_reg[gi] <= cmp_a;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sort4_ctrl.sv
// Drives an ascending and a descending sorter with identical stimulus and checks both
// against a plain bubble-sort reference model.
module tb_sort4_ctrl;

  localparam int N = 4;
  typedef logic [3:0] arr_t [N];

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [1:0] load_idx;
  logic [3:0] load_data;
  logic       start;
  logic [1:0] rd_idx;

  logic       busy_a, done_a, busy_d, done_d;
  logic [3:0] cnt_a, cnt_d, rd_a, rd_d;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sort4_ctrl #(.N(4), .IDX_W(2), .CNT_W(4), .DESCEND(1'b0)) u_asc (
    .clk(clk), .rst(rst), .load(load), .load_idx(load_idx), .load_data(load_data),
    .start(start), .busy(busy_a), .done(done_a), .swap_cnt(cnt_a),
    .rd_idx(rd_idx), .rd_data(rd_a)
  );

  sort4_ctrl #(.N(4), .IDX_W(2), .CNT_W(4), .DESCEND(1'b1)) u_desc (
    .clk(clk), .rst(rst), .load(load), .load_idx(load_idx), .load_data(load_data),
    .start(start), .busy(busy_d), .done(done_d), .swap_cnt(cnt_d),
    .rd_idx(rd_idx), .rd_data(rd_d)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference bubble sort: returns the final array, swap count and number of compares.
  function automatic void model(input arr_t v, input bit desc, output arr_t r,
                                output int swaps, output int k);
    logic [3:0] t;
    bit         any;
    r = v;
    swaps = 0;
    k = 0;
    for (int p = 0; p <= N - 2; p++) begin
      any = 0;
      for (int j = 0; j <= N - 2 - p; j++) begin
        k++;
        if (desc ? (r[j] < r[j+1]) : (r[j] > r[j+1])) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
          swaps++;
          any = 1;
        end
      end
      if (!any) break;
    end
  endfunction

  task automatic load_all(input arr_t v);
    for (int i = 0; i < N; i++) begin
      load = 1'b1; load_idx = 2'(i); load_data = v[i];
      tick();
    end
    load = 1'b0;
  endtask

  task automatic check_arrays(input string tag, input arr_t ea, input arr_t ed);
    for (int i = 0; i < N; i++) begin
      rd_idx = 2'(i);
      #1;
      check({tag, "_asc_rd"}, 32'(rd_a), 32'(ea[i]));
      check({tag, "_desc_rd"}, 32'(rd_d), 32'(ed[i]));
    end
  endtask

  // Load, start, follow both sorters cycle by cycle, then check results.
  // When inject is set, start and a load to entry 0 are pulsed in cycle 2.
  task automatic run_sort(input string tag, input arr_t v, input bit inject);
    arr_t ra, rd;
    int   sa, sd, ka, kd, kmax;
    model(v, 1'b0, ra, sa, ka);
    model(v, 1'b1, rd, sd, kd);
    kmax = (ka > kd) ? ka : kd;
    load_all(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= kmax + 1; c++) begin
      check({tag, "_asc_busy"}, 32'(busy_a), 32'(c <= ka));
      check({tag, "_asc_done"}, 32'(done_a), 32'(c == ka + 1));
      check({tag, "_desc_busy"}, 32'(busy_d), 32'(c <= kd));
      check({tag, "_desc_done"}, 32'(done_d), 32'(c == kd + 1));
      if (inject && c == 2) begin
        start = 1'b1; load = 1'b1; load_idx = 2'd0; load_data = 4'hF;
      end
      tick();
      start = 1'b0; load = 1'b0;
    end
    check({tag, "_asc_done_clear"}, 32'(done_a), 32'd0);
    check({tag, "_desc_done_clear"}, 32'(done_d), 32'd0);
    check({tag, "_asc_swaps"}, 32'(cnt_a), 32'(sa));
    check({tag, "_desc_swaps"}, 32'(cnt_d), 32'(sd));
    check_arrays(tag, ra, rd);
    $display("sort %s in=[%0d,%0d,%0d,%0d] asc K=%0d swaps=%0d desc K=%0d swaps=%0d",
             tag, v[0], v[1], v[2], v[3], ka, sa, kd, sd);
  endtask

  initial begin
    arr_t v, zero;
    zero = '{4'd0, 4'd0, 4'd0, 4'd0};
    rst = 1'b1; load = 1'b0; load_idx = '0; load_data = '0; start = 1'b0; rd_idx = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_asc_busy", 32'(busy_a), 32'd0);
    check("rst_asc_done", 32'(done_a), 32'd0);
    check("rst_asc_cnt", 32'(cnt_a), 32'd0);
    check("rst_desc_cnt", 32'(cnt_d), 32'd0);
    check_arrays("rst", zero, zero);

    v = '{4'd9, 4'd3, 4'd7, 4'd1};  run_sort("t1", v, 1'b0);
    v = '{4'd1, 4'd2, 4'd3, 4'd4};  run_sort("t2", v, 1'b0);
    v = '{4'd5, 4'd5, 4'd5, 4'd5};  run_sort("t3", v, 1'b0);
    v = '{4'd2, 4'd8, 4'd4, 4'd6};  run_sort("t4", v, 1'b0);
    v = '{4'd9, 4'd3, 4'd7, 4'd1};  run_sort("t5_ignored", v, 1'b1);

    // Reset mid-sort discards all progress.
    v = '{4'd9, 4'd3, 4'd7, 4'd1};
    load_all(v);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_asc_busy", 32'(busy_a), 32'd0);
    check("t6_asc_done", 32'(done_a), 32'd0);
    check("t6_asc_cnt", 32'(cnt_a), 32'd0);
    check("t6_desc_busy", 32'(busy_d), 32'd0);
    check("t6_desc_cnt", 32'(cnt_d), 32'd0);
    check_arrays("t6", zero, zero);
    $display("sort t6 reset mid-sort checked");
    v = '{4'd6, 4'd0, 4'd15, 4'd6}; run_sort("t6_after", v, 1'b0);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < N; i++) v[i] = 4'($urandom_range(0, 15));
      run_sort($sformatf("rnd%0d", n), v, (n % 4) == 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
